// File: rtl/exp_align_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : exp_align_pipe
//  Description : Two-stage exponent compare / operand swap / mantissa
//                alignment front end for the FPU add/sub datapath. Orders
//                the operands by magnitude, right-shifts the smaller mantissa
//                by the exponent difference and folds the shifted-out bits
//                into a sticky bit. Valid/ready handshake with backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module exp_align_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic               i_sign_a,
    input  logic [EXP_W-1:0]   i_exp_a,
    input  logic [MAN_W-1:0]   i_man_a,
    input  logic               i_sign_b,
    input  logic [EXP_W-1:0]   i_exp_b,
    input  logic [MAN_W-1:0]   i_man_b,
    input  logic               i_op,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_swapped,
    output logic               o_sign_greater,
    output logic               o_sign_less,
    output logic               o_eff_sub,
    output logic [EXP_W-1:0]   o_exp_greater,
    output logic [EXP_W-1:0]   o_exp_diff,
    output logic [MAN_W+3:0]   o_man_greater,
    output logic [MAN_W+3:0]   o_man_less
);

    // Extended mantissa: {hidden, fraction, guard, round, sticky}
    localparam int          c_XW        = MAN_W + 4;
    // Any shift at or beyond this distance leaves only the sticky bit
    localparam logic [31:0] c_FAR_SHIFT = 32'(MAN_W + 3);

    // ------------------------------------------------------------------
    // Handshake: both stages advance together whenever the output slot
    // is empty or being drained this cycle.
    // ------------------------------------------------------------------
    logic w_en;
    logic r_valid;

    assign w_en    = ~r_valid | i_ready;
    assign o_ready = w_en;

    // ------------------------------------------------------------------
    // Stage 1 combinational: op adjust, effective exponents, ordering
    // ------------------------------------------------------------------
    logic             w_sign_b_adj;
    logic             w_hid_a;
    logic             w_hid_b;
    logic [EXP_W-1:0] w_eexp_a;
    logic [EXP_W-1:0] w_eexp_b;
    logic [MAN_W:0]   w_sig_a;
    logic [MAN_W:0]   w_sig_b;
    logic             w_swap;

    assign w_sign_b_adj = i_sign_b ^ i_op;
    assign w_hid_a      = |i_exp_a;
    assign w_hid_b      = |i_exp_b;
    // Denormals behave as exponent 1 so they line up with the smallest normals
    assign w_eexp_a     = w_hid_a ? i_exp_a : EXP_W'(1);
    assign w_eexp_b     = w_hid_b ? i_exp_b : EXP_W'(1);
    assign w_sig_a      = {w_hid_a, i_man_a};
    assign w_sig_b      = {w_hid_b, i_man_b};
    // Full ties keep A as the greater operand
    assign w_swap       = (w_eexp_a < w_eexp_b) |
                          ((w_eexp_a == w_eexp_b) & (w_sig_a < w_sig_b));

    logic             r_s1_valid;
    logic             r_s1_swap;
    logic             r_s1_sign_g;
    logic             r_s1_sign_l;
    logic [EXP_W-1:0] r_s1_exp_g;
    logic [EXP_W-1:0] r_s1_diff;
    logic [MAN_W:0]   r_s1_sig_g;
    logic [MAN_W:0]   r_s1_sig_l;

    // Stage 1 register: capture ordered operands and exponent difference
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_swap   <= 1'b0;
            r_s1_sign_g <= 1'b0;
            r_s1_sign_l <= 1'b0;
            r_s1_exp_g  <= '0;
            r_s1_diff   <= '0;
            r_s1_sig_g  <= '0;
            r_s1_sig_l  <= '0;
        end else if (w_en) begin
            r_s1_valid  <= i_valid;
            r_s1_swap   <= w_swap;
            r_s1_sign_g <= w_swap ? w_sign_b_adj : i_sign_a;
            r_s1_sign_l <= w_swap ? i_sign_a     : w_sign_b_adj;
            r_s1_exp_g  <= w_swap ? w_eexp_b     : w_eexp_a;
            r_s1_diff   <= w_swap ? (w_eexp_b - w_eexp_a) : (w_eexp_a - w_eexp_b);
            r_s1_sig_g  <= w_swap ? w_sig_b      : w_sig_a;
            r_s1_sig_l  <= w_swap ? w_sig_a      : w_sig_b;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: right-shift the lesser mantissa with sticky
    // ------------------------------------------------------------------
    logic [c_XW-1:0] w_ext_l;
    logic [c_XW-1:0] w_shifted;
    logic [c_XW-1:0] w_lost_mask;
    logic            w_lost;
    logic            w_far;
    logic [c_XW-1:0] w_aligned;

    assign w_ext_l     = {r_s1_sig_l, 3'b000};
    assign w_far       = 32'(r_s1_diff) >= c_FAR_SHIFT;
    assign w_shifted   = w_ext_l >> r_s1_diff;
    // Ones in exactly the bit positions that fall off the bottom
    assign w_lost_mask = ~({c_XW{1'b1}} << r_s1_diff);
    assign w_lost      = |(w_ext_l & w_lost_mask);
    assign w_aligned   = w_far ? {{(c_XW-1){1'b0}}, |w_ext_l}
                               : {w_shifted[c_XW-1:1], w_shifted[0] | w_lost};

    logic             r_swapped;
    logic             r_sign_g;
    logic             r_sign_l;
    logic             r_eff_sub;
    logic [EXP_W-1:0] r_exp_g;
    logic [EXP_W-1:0] r_exp_diff;
    logic [c_XW-1:0]  r_man_g;
    logic [c_XW-1:0]  r_man_l;

    // Stage 2 register: aligned mantissas and final operand attributes
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid    <= 1'b0;
            r_swapped  <= 1'b0;
            r_sign_g   <= 1'b0;
            r_sign_l   <= 1'b0;
            r_eff_sub  <= 1'b0;
            r_exp_g    <= '0;
            r_exp_diff <= '0;
            r_man_g    <= '0;
            r_man_l    <= '0;
        end else if (w_en) begin
            r_valid    <= r_s1_valid;
            r_swapped  <= r_s1_swap;
            r_sign_g   <= r_s1_sign_g;
            r_sign_l   <= r_s1_sign_l;
            r_eff_sub  <= r_s1_sign_g ^ r_s1_sign_l;
            r_exp_g    <= r_s1_exp_g;
            r_exp_diff <= r_s1_diff;
            r_man_g    <= {r_s1_sig_g, 3'b000};
            r_man_l    <= w_aligned;
        end
    end

    assign o_valid        = r_valid;
    assign o_swapped      = r_swapped;
    assign o_sign_greater = r_sign_g;
    assign o_sign_less    = r_sign_l;
    assign o_eff_sub      = r_eff_sub;
    assign o_exp_greater  = r_exp_g;
    assign o_exp_diff     = r_exp_diff;
    assign o_man_greater  = r_man_g;
    assign o_man_less     = r_man_l;

endmodule
`default_nettype wire
